// File: rtl/mdio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mdio_pkg                                                    |
// | Purpose  : Shared definitions for the Clause 22 MDIO PHY responder:    |
// |            frame-walker state encoding, opcodes, register indices and |
// |            register bit positions.                                     |
// | Ports    : none (package)                                              |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package mdio_pkg;

  // One state per MDIO frame field; each state consumes one bit per MDC edge.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_OP    = 3'd2,
    ST_PHYAD = 3'd3,
    ST_REGAD = 3'd4,
    ST_TA    = 3'd5,
    ST_DATA  = 3'd6
  } mdio_state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] BMCR = 5'd0;
  localparam logic [4:0] BMSR = 5'd1;
  localparam logic [4:0] ID1  = 5'd2;
  localparam logic [4:0] ID2  = 5'd3;

  localparam int BMCR_RST  = 15;
  localparam int BMSR_LINK = 2;

  // Fixed BMSR capability bits (100BASE-TX/10BASE-T FD/HD, AN able, AN
  // complete, preamble suppression, extended capability); link bit is OR-ed in.
  localparam logic [15:0] BMSR_FIXED = 16'h7969;

endpackage : mdio_pkg
`default_nettype wire

// File: rtl/mdio_phy_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mdio_phy_responder_if                                       |
// | Purpose  : Bundles the MDIO pad signals and the local datapath         |
// |            side-band of the PHY responder.                             |
// | Signals  : mdc_i, mdio_i, link_up_i  (master -> responder)             |
// |            mdio_o, mdio_oe, ctrl_o[15:0], wr_evt_o, wr_addr_o[4:0]     |
// |            (responder -> master / datapath)                            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface mdio_phy_responder_if;
  logic        mdc_i;
  logic        mdio_i;
  logic        link_up_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [15:0] ctrl_o;
  logic        wr_evt_o;
  logic [4:0]  wr_addr_o;

  modport master (
    output mdc_i, mdio_i, link_up_i,
    input  mdio_o, mdio_oe, ctrl_o, wr_evt_o, wr_addr_o
  );

  modport slave (
    input  mdc_i, mdio_i, link_up_i,
    output mdio_o, mdio_oe, ctrl_o, wr_evt_o, wr_addr_o
  );
endinterface : mdio_phy_responder_if
`default_nettype wire

// File: rtl/mdio_edge_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mdio_edge_sync                                              |
// | Purpose  : Two-flop synchronizers for MDC and MDIO plus an MDC rising  |
// |            edge strobe taken from the synchronized stage.              |
// | Ports    : clk_i, rst_i (async, active-high)                           |
// |            mdc_i, mdio_i        asynchronous pad inputs                |
// |            mdc_rise_o           1-clk strobe per MDC rising edge       |
// |            mdio_sync_o          synchronized MDIO, aligned to strobe   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module mdio_edge_sync (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic mdc_i,
  input  wire logic mdio_i,
  output logic      mdc_rise_o,
  output logic      mdio_sync_o
);

  // Third MDC stage only remembers the previous synced value for edge detect.
  logic [2:0] r_mdc_sync;
  logic [1:0] r_mdio_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mdc_sync  <= 3'b000;
      r_mdio_sync <= 2'b11;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[1:0], mdc_i};
      r_mdio_sync <= {r_mdio_sync[0], mdio_i};
    end
  end

  assign mdc_rise_o  = r_mdc_sync[1] & ~r_mdc_sync[2];
  assign mdio_sync_o = r_mdio_sync[1];

endmodule : mdio_edge_sync
`default_nettype wire

// File: rtl/mdio_phy_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mdio_phy_responder                                          |
// | Purpose  : PHY-side Clause 22 MDIO responder with an internal 32x16    |
// |            register file; answers reads, commits writes and exports   |
// |            the control register to the local datapath.                 |
// | Ports    : clk_i  system clock (>= 8x MDC)                             |
// |            rst_i  asynchronous reset, active-high                      |
// |            bus    slave modport: mdc_i, mdio_i, link_up_i in;          |
// |                   mdio_o, mdio_oe, ctrl_o, wr_evt_o, wr_addr_o out     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int unsigned PREAMBLE_MIN = 0,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter logic [15:0] CTRL_RST_VAL = 16'h1140
) (
  input wire logic clk_i,
  input wire logic rst_i,
  mdio_phy_responder_if.slave bus
);

  logic w_mdc_rise;
  logic w_bit;

  mdio_edge_sync u_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mdc_i       (bus.mdc_i),
    .mdio_i      (bus.mdio_i),
    .mdc_rise_o  (w_mdc_rise),
    .mdio_sync_o (w_bit)
  );

  mdio_state_t r_state;
  logic [5:0]  r_pre_cnt;     // consecutive preamble 1s, saturates at 32
  logic [4:0]  r_bit_cnt;     // bit index within the current field
  logic        r_op_hi;       // first opcode bit
  logic        r_is_read;
  logic [3:0]  r_phyad;       // first four PHYAD bits
  logic        r_match;
  logic [4:0]  r_regad;
  logic [15:0] r_snap;        // read data, shifted out MSB first
  logic [14:0] r_shift;       // write data collected so far
  logic        r_mdio_o;
  logic        r_mdio_oe;
  logic        r_wr_evt;
  logic [4:0]  r_wr_addr;
  logic [15:0] r_ctrl;        // register 0
  logic [15:0] r_regs [4:31]; // general R/W registers

  logic [4:0]  w_regad_next;
  logic [15:0] w_rd_data;
  logic [15:0] w_wdata;
  logic        w_drive;

  assign w_regad_next = {r_regad[3:0], w_bit};
  assign w_wdata      = {r_shift, w_bit};
  assign w_drive      = r_is_read & r_match;

  // Read mux evaluated on the last REGAD bit so the snapshot sees the
  // complete address.
  always_comb begin
    w_rd_data = 16'h0000;
    case (w_regad_next)
      BMCR: w_rd_data = r_ctrl;
      BMSR: begin
        w_rd_data            = BMSR_FIXED;
        w_rd_data[BMSR_LINK] = bus.link_up_i;
      end
      ID1:     w_rd_data = PHY_ID1;
      ID2:     w_rd_data = PHY_ID2;
      default: w_rd_data = r_regs[w_regad_next];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_pre_cnt <= 6'd0;
      r_bit_cnt <= 5'd0;
      r_op_hi   <= 1'b0;
      r_is_read <= 1'b0;
      r_phyad   <= 4'd0;
      r_match   <= 1'b0;
      r_regad   <= 5'd0;
      r_snap    <= 16'h0000;
      r_shift   <= 15'd0;
      r_mdio_o  <= 1'b1;
      r_mdio_oe <= 1'b0;
      r_wr_evt  <= 1'b0;
      r_wr_addr <= 5'd0;
      r_ctrl    <= CTRL_RST_VAL;
      for (int i = 4; i < 32; i++) r_regs[i] <= 16'h0000;
    end else begin
      r_wr_evt <= 1'b0;
      if (w_mdc_rise) begin
        case (r_state)
          ST_IDLE: begin
            if (w_bit) begin
              if (r_pre_cnt != 6'd32) r_pre_cnt <= r_pre_cnt + 6'd1;
            end else begin
              r_pre_cnt <= 6'd0;
              if ({26'd0, r_pre_cnt} >= PREAMBLE_MIN) r_state <= ST_START;
            end
          end

          ST_START: begin
            r_bit_cnt <= 5'd0;
            r_state   <= w_bit ? ST_OP : ST_IDLE;
          end

          ST_OP: begin
            if (r_bit_cnt == 5'd0) begin
              r_op_hi   <= w_bit;
              r_bit_cnt <= 5'd1;
            end else begin
              r_bit_cnt <= 5'd0;
              case ({r_op_hi, w_bit})
                OP_READ: begin
                  r_is_read <= 1'b1;
                  r_state   <= ST_PHYAD;
                end
                OP_WRITE: begin
                  r_is_read <= 1'b0;
                  r_state   <= ST_PHYAD;
                end
                default: r_state <= ST_IDLE;
              endcase
            end
          end

          ST_PHYAD: begin
            r_phyad <= {r_phyad[2:0], w_bit};
            if (r_bit_cnt == 5'd4) begin
              r_match   <= ({r_phyad, w_bit} == PHY_ADDR);
              r_bit_cnt <= 5'd0;
              r_state   <= ST_REGAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          ST_REGAD: begin
            r_regad <= w_regad_next;
            if (r_bit_cnt == 5'd4) begin
              r_snap    <= w_rd_data;
              r_bit_cnt <= 5'd0;
              r_state   <= ST_TA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          // Outputs set on an edge are what the master samples on the next
          // edge: the first TA bit stays released, the second carries the
          // PHY's 0, and each later edge queues the next data bit.
          ST_TA: begin
            if (r_bit_cnt == 5'd0) begin
              r_bit_cnt <= 5'd1;
              if (w_drive) begin
                r_mdio_oe <= 1'b1;
                r_mdio_o  <= 1'b0;
              end
            end else begin
              r_bit_cnt <= 5'd0;
              r_state   <= ST_DATA;
              if (w_drive) begin
                r_mdio_o <= r_snap[15];
                r_snap   <= {r_snap[14:0], 1'b0};
              end
            end
          end

          ST_DATA: begin
            r_shift <= {r_shift[13:0], w_bit};
            if (r_bit_cnt == 5'd15) begin
              r_mdio_oe <= 1'b0;
              r_mdio_o  <= 1'b1;
              r_bit_cnt <= 5'd0;
              r_pre_cnt <= 6'd0;
              r_state   <= ST_IDLE;
              if (!r_is_read && r_match) begin
                r_wr_evt  <= 1'b1;
                r_wr_addr <= r_regad;
                case (r_regad)
                  BMCR: begin
                    // Self-clearing soft reset: restore every R/W register.
                    if (w_wdata[BMCR_RST]) begin
                      r_ctrl <= CTRL_RST_VAL;
                      for (int i = 4; i < 32; i++) r_regs[i] <= 16'h0000;
                    end else begin
                      r_ctrl <= w_wdata;
                    end
                  end
                  BMSR, ID1, ID2: ;  // read-only, write discarded
                  default: r_regs[r_regad] <= w_wdata;
                endcase
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (w_drive) begin
                r_mdio_o <= r_snap[15];
                r_snap   <= {r_snap[14:0], 1'b0};
              end
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.mdio_o    = r_mdio_o;
  assign bus.mdio_oe   = r_mdio_oe;
  assign bus.ctrl_o    = r_ctrl;
  assign bus.wr_evt_o  = r_wr_evt;
  assign bus.wr_addr_o = r_wr_addr;

endmodule : mdio_phy_responder
`default_nettype wire

// File: tb/tb_mdio_phy_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mdio_phy_responder                                       |
// | Purpose  : Self-checking bench: an MDIO master (MDC = clk/16) issues   |
// |            directed and random frames; expected read data and write   |
// |            events come from a register-map model and are queued; two  |
// |            monitors compare what the responder actually presents.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_mdio_phy_responder;

  logic clk;
  logic rst;
  logic m_oe;   // master currently drives the MDIO wire
  logic m_val;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_rd[$];
  logic [4:0]  exp_wr[$];
  logic [15:0] model_regs [0:31];
  bit          drop_partial = 0;

  mdio_phy_responder_if ifc ();

  // Open-drain style wire with pull-up: master, else responder, else 1.
  assign ifc.mdio_i = m_oe ? m_val : (ifc.mdio_oe ? ifc.mdio_o : 1'b1);

  mdio_phy_responder #(
    .PHY_ADDR     (5'd0),
    .PREAMBLE_MIN (0),
    .PHY_ID1      (16'h0141),
    .PHY_ID2      (16'h0CC2),
    .CTRL_RST_VAL (16'h1140)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference register map ----------------
  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
    model_regs[0] = 16'h1140;
  endfunction

  function automatic logic [15:0] model_read(input logic [4:0] a, input logic link);
    if (a == 5'd1) return link ? 16'h796D : 16'h7969;
    if (a == 5'd2) return 16'h0141;
    if (a == 5'd3) return 16'h0CC2;
    return model_regs[a];
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [15:0] d);
    if (a >= 5'd1 && a <= 5'd3) return;
    if (a == 5'd0 && d[15]) model_reset();
    else model_regs[a] = d;
  endfunction

  // ---------------- MDIO master ----------------
  task automatic send_bit(input logic drive, input logic val);
    ifc.mdc_i = 1'b0;
    m_oe      = drive;
    m_val     = val;
    repeat (8) @(negedge clk);
    ifc.mdc_i = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input int abort_at);
    bit is_rd, is_wr, hit;
    logic [4:0]  p;
    logic [4:0]  r;
    logic [15:0] d;
    is_rd = (op == 2'b10);
    is_wr = (op == 2'b01);
    hit   = (phy == 5'd0);
    // After a bad opcode the responder is idle again; all-ones fields keep
    // the rest of the wire from looking like a fresh start sequence.
    p = (is_rd || is_wr) ? phy : 5'h1F;
    r = (is_rd || is_wr) ? ra  : 5'h1F;
    d = is_wr ? wd : 16'hFFFF;
    for (int i = 0; i < 32; i++) send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 1; i >= 0; i--) send_bit(1'b1, op[i]);
    for (int i = 4; i >= 0; i--) send_bit(1'b1, p[i]);
    for (int i = 4; i >= 0; i--) send_bit(1'b1, r[i]);
    if (is_rd && hit && abort_at < 0) exp_rd.push_back(model_read(ra, ifc.link_up_i));
    if (is_wr && hit) exp_wr.push_back(ra);
    if (is_wr) begin
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
    end else begin
      send_bit(!is_rd, 1'b1);
      send_bit(!is_rd, 1'b1);
    end
    for (int i = 15; i >= 0; i--) begin
      if (is_rd && (15 - i) == abort_at) begin
        chk("oe_before_rst", 32'(ifc.mdio_oe), 32'd1);
        drop_partial = 1;
        rst = 1'b1;
        #1;
        chk("oe_at_rst", 32'(ifc.mdio_oe), 32'd0);
        chk("mdio_o_at_rst", 32'(ifc.mdio_o), 32'd1);
        chk("ctrl_at_rst", 32'(ifc.ctrl_o), 32'h1140);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        return;
      end
      send_bit(!is_rd, d[i]);
    end
    if (is_wr && hit) model_write(ra, wd);
    send_bit(1'b1, 1'b1);
    chk("ctrl_o", 32'(ifc.ctrl_o), 32'(model_regs[0]));
  endtask

  // ---------------- monitors ----------------
  // Collect every bit the responder drives at MDC rising edges; a burst ends
  // on the first edge with the driver released.
  initial begin : mon_read
    logic [16:0] bits;
    int nb;
    bits = '0;
    nb   = 0;
    forever begin
      @(posedge ifc.mdc_i);
      if (ifc.mdio_oe) begin
        bits = {bits[15:0], ifc.mdio_o};
        nb++;
      end else if (nb != 0) begin
        if (drop_partial) begin
          drop_partial = 0;
        end else begin
          chk("rd_oe_bits", 32'(nb), 32'd17);
          chk("rd_ta0", 32'(bits[16]), 32'd0);
          if (exp_rd.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL rd_unexpected: got %h expected no drive", bits[15:0]);
          end else begin
            chk("rd_data", 32'(bits[15:0]), 32'(exp_rd.pop_front()));
          end
        end
        nb = 0;
      end
    end
  end

  initial begin : mon_write
    forever begin
      @(negedge clk);
      if (ifc.wr_evt_o === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL wr_unexpected: got addr %h expected no pulse", ifc.wr_addr_o);
        end else begin
          chk("wr_addr", 32'(ifc.wr_addr_o), 32'(exp_wr.pop_front()));
        end
        @(negedge clk);
        chk("wr_pulse_width", 32'(ifc.wr_evt_o), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] wd;
    int unsigned r;
    rst           = 1'b1;
    m_oe          = 1'b1;
    m_val         = 1'b1;
    ifc.mdc_i     = 1'b0;
    ifc.link_up_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mdio_oe", 32'(ifc.mdio_oe), 32'd0);
    chk("rst_mdio_o", 32'(ifc.mdio_o), 32'd1);
    chk("rst_wr_evt", 32'(ifc.wr_evt_o), 32'd0);
    chk("rst_wr_addr", 32'(ifc.wr_addr_o), 32'd0);
    chk("rst_ctrl", 32'(ifc.ctrl_o), 32'h1140);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // IDs, then a write/read-back, then a write to a different PHY.
    frame(2'b10, 5'd0, 5'd2, 16'h0, -1);
    frame(2'b10, 5'd0, 5'd3, 16'h0, -1);
    frame(2'b01, 5'd0, 5'd4, 16'hABCD, -1);
    frame(2'b10, 5'd0, 5'd4, 16'h0, -1);
    frame(2'b01, 5'd1, 5'd4, 16'h1234, -1);
    frame(2'b10, 5'd0, 5'd4, 16'h0, -1);
    // Soft reset through BMCR bit 15.
    frame(2'b01, 5'd0, 5'd0, 16'h8000, -1);
    frame(2'b10, 5'd0, 5'd4, 16'h0, -1);
    frame(2'b10, 5'd0, 5'd0, 16'h0, -1);
    // Status register with link up/down; writes to it are discarded.
    ifc.link_up_i = 1'b1;
    frame(2'b10, 5'd0, 5'd1, 16'h0, -1);
    ifc.link_up_i = 1'b0;
    frame(2'b10, 5'd0, 5'd1, 16'h0, -1);
    frame(2'b01, 5'd0, 5'd1, 16'h0000, -1);
    frame(2'b10, 5'd0, 5'd1, 16'h0, -1);
    // Bad opcode, then reset in the middle of a read, then a clean read.
    frame(2'b01, 5'd0, 5'd7, 16'h5A5A, -1);
    frame(2'b11, 5'd0, 5'd2, 16'h0, -1);
    frame(2'b10, 5'd0, 5'd2, 16'h0, 8);
    frame(2'b10, 5'd0, 5'd7, 16'h0, -1);
    frame(2'b10, 5'd0, 5'd3, 16'h0, -1);

    for (int k = 0; k < 24; k++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b10 : ((r < 8) ? 2'b01 : 2'b11);
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      ra  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      wd  = 16'($urandom);
      if (ra == 5'd0 && $urandom_range(0, 3) != 0) wd[15] = 1'b0;
      ifc.link_up_i = 1'($urandom_range(0, 1));
      frame(op, phy, ra, wd, -1);
    end

    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mdio_phy_responder
`default_nettype wire
